counter_step_monitor: RTL
=========================

// Module: counter_step_monitor
// PURPOSE
//  Observer for the selectable-rate 4-bit up/down counter output bus.
//  Checks each value change for a unit step and recovers direction (up/down).
//  Measures the interval between changes and classifies the rate as slow or fast.
//  Flags illegal steps, out-of-window intervals and stalls; used on-board and in benches.
// PARAMETERS
//  DATA_W       4         width of observed counter value
//  CNT_W        28        interval counter width
//  SLOW_TICKS   25000000  nominal clk cycles between changes, slow rate
//  FAST_TICKS   250000    nominal clk cycles between changes, fast rate
//  TOL          16        +/- cycles accepted around each nominal interval
//  STALL_TICKS  50000000  cycles without change before stall is declared
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-low
//  cnt_in     in   DATA_W  observed counter value, same clock domain
//  evt        out  1       1-cycle pulse: a change of cnt_in was processed
//  dir        out  1       last legal step direction: 0=up(+1), 1=down(-1)
//  hz_det     out  1       last classified rate: 0=slow, 1=fast
//  valid      out  1       dir/hz_det reflect a legal, in-window step
//  step_err   out  1       sticky: non-unit step seen
//  rate_err   out  1       sticky: interval outside both windows
//  stalled    out  1       no change for STALL_TICKS cycles
//  interval   out  CNT_W   last measured interval (cycles)
// BEHAVIOUR
//  Reset
//   - rst=0 at a clk edge clears all outputs, interval and state; state=IDLE.
//   - Applies mid-operation with no residue.
//  Tracking and change detection
//   - last_q holds the previous cnt_in sample.
//   - Change = cnt_in != last_q at an edge.
//   - Outputs update at that same edge, so they are visible 1 cycle after the change.
//  Step decode
//   - delta = cnt_in - last_q, mod 2^DATA_W.
//   - delta==1: up, dir=0. delta==all-ones: down, dir=1 (covers wrap 15->0 and 0->15).
//   - Any other delta: step_err<=1, valid<=0, dir held.
//  Interval timer
//   - ivl clears to 0 on a change, else increments, saturating at 2^CNT_W-1.
//   - Measured interval = ivl+1, latched into interval on every change.
//  Rate classification (only in ARMED/LOCKED)
//   - |m-SLOW_TICKS|<=TOL: hz_det=0.
//   - |m-FAST_TICKS|<=TOL: hz_det=1.
//   - Otherwise rate_err<=1, valid<=0, hz_det held.
//   - Window compare is unsigned; no underflow if TOL>FAST_TICKS (low bound clamps at 0).
//  FSM
//   - IDLE: first cycle after reset. Loads last_q, no evt. Goes to WAIT.
//   - WAIT: a change pulses evt and decodes the step. No interval is classified;
//     interval is still latched. Goes to ARMED.
//   - ARMED: a change with legal step and in-window interval sets valid=1 and goes
//     to LOCKED. An illegal step or out-of-window interval stays in ARMED.
//   - LOCKED: a legal step in window keeps valid=1. An illegal step or out-of-window
//     interval clears valid and goes to ARMED.
//   - Any state except IDLE: ivl reaching STALL_TICKS sets stalled=1 and valid=0,
//     and goes to WAIT. The next change clears stalled.
//  Simultaneous events
//   - Change on the same edge as the stall threshold: the change wins; stalled stays 0.
//   - Direction reversal (up then down) is legal; dir follows each step.
//   - step_err and rate_err clear only on reset.
// STRUCTURE
//  Package cnt_mon_pkg
//   - DIR_UP/DIR_DOWN, RATE_SLOW/RATE_FAST constants, matching the counter's
//     control/hz encodings.
//   - FSM state typedef {IDLE, WAIT, ARMED, LOCKED}.
//  Sub-module step_interval_timer
//   - Saturating ivl counter with clear.
//   - stall compare and window classifier.
//   - Outputs: in_slow, in_fast, stall_hit.
//  Top: change/step decode, FSM, output and sticky-flag registers.
// TESTING (bench overrides: SLOW_TICKS=100, FAST_TICKS=10, TOL=2, STALL_TICKS=200)
//  1. Up count 0..15 then wrap to 0, every 100 cycles.
//     -> From the 2nd change on: valid=1, dir=0, hz_det=0, interval=100.
//     -> The 15->0 wrap is legal.
//  2. Down count every 10 cycles from 3 (2,1,0,15,...).
//     -> dir=1, hz_det=1, interval=10, no errors.
//  3. In LOCKED: step 4->6 at a nominal interval.
//     -> step_err=1, valid=0, state ARMED.
//     -> Next legal step at 100 cycles: valid=1 again; step_err stays 1.
//  4. Intervals of 98 and 102 cycles -> accepted.
//     Interval of 50 -> rate_err=1, valid=0.
//  5. Hold cnt_in 200 cycles -> stalled=1, valid=0.
//     Next change -> stalled=0, evt=1, valid=0.
//     Following 100-cycle step -> valid=1.
//  6. rst=0 for one edge mid-LOCKED -> all outputs 0.
//     First change after reset gives evt but valid=0.

Source files
------------

// File: rtl/cnt_mon_pkg.sv
// Shared encodings for the counter step monitor: direction and rate values
// match the observed counter's control/hz inputs, plus the monitor FSM states.
package cnt_mon_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic RATE_SLOW = 1'b0;
    localparam logic RATE_FAST = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ARMED  = 2'd2,
        LOCKED = 2'd3
    } state_t;

endpackage

// File: rtl/step_interval_timer.sv
// Saturating cycles-since-last-change counter with stall detection and
// slow/fast window classification of the measured interval (ivl + 1).
module step_interval_timer
    import cnt_mon_pkg::*;
#(
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned SLOW_TICKS  = 25000000,
    parameter int unsigned FAST_TICKS  = 250000,
    parameter int unsigned TOL         = 16,
    parameter int unsigned STALL_TICKS = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] meas,
    output logic             in_slow,
    output logic             in_fast,
    output logic             stall_hit
);

    localparam logic [CNT_W-1:0] IVL_MAX = '1;
    // Window bounds are one bit wider than the counter so ivl+1 never wraps;
    // the low bound clamps at zero when the tolerance exceeds the nominal.
    localparam logic [CNT_W:0] SLOW_LO  = (CNT_W+1)'((SLOW_TICKS > TOL) ? SLOW_TICKS - TOL : 0);
    localparam logic [CNT_W:0] SLOW_HI  = (CNT_W+1)'(SLOW_TICKS + TOL);
    localparam logic [CNT_W:0] FAST_LO  = (CNT_W+1)'((FAST_TICKS > TOL) ? FAST_TICKS - TOL : 0);
    localparam logic [CNT_W:0] FAST_HI  = (CNT_W+1)'(FAST_TICKS + TOL);
    localparam logic [CNT_W:0] STALL_TH = (CNT_W+1)'(STALL_TICKS);

    logic [CNT_W-1:0] ivl_q, ivl_d;
    logic [CNT_W:0]   meas_ext;

    always_comb begin
        ivl_d = ivl_q;
        if (clear) begin
            ivl_d = '0;
        end else if (ivl_q != IVL_MAX) begin
            ivl_d = ivl_q + 1'b1;
        end
    end

    always_comb begin
        meas_ext  = {1'b0, ivl_q} + {{CNT_W{1'b0}}, 1'b1};
        meas      = (ivl_q == IVL_MAX) ? IVL_MAX : meas_ext[CNT_W-1:0];
        in_slow   = (meas_ext >= SLOW_LO) && (meas_ext <= SLOW_HI);
        in_fast   = (meas_ext >= FAST_LO) && (meas_ext <= FAST_HI);
        stall_hit = (meas_ext >= STALL_TH);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ivl_q <= '0;
        end else begin
            ivl_q <= ivl_d;
        end
    end

endmodule

// File: rtl/counter_step_monitor.sv
// Observer for an up/down counter bus: checks each change is a unit step,
// recovers direction, classifies the change rate and flags errors/stalls.
module counter_step_monitor
    import cnt_mon_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned SLOW_TICKS  = 25000000,
    parameter int unsigned FAST_TICKS  = 250000,
    parameter int unsigned TOL         = 16,
    parameter int unsigned STALL_TICKS = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cnt_in,
    output logic              evt,
    output logic              dir,
    output logic              hz_det,
    output logic              valid,
    output logic              step_err,
    output logic              rate_err,
    output logic              stalled,
    output logic [CNT_W-1:0]  interval,
    output state_t            state_dbg
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              evt_q, evt_d;
    logic              dir_q, dir_d;
    logic              hz_q, hz_d;
    logic              valid_q, valid_d;
    logic              step_err_q, step_err_d;
    logic              rate_err_q, rate_err_d;
    logic              stalled_q, stalled_d;
    logic [CNT_W-1:0]  interval_q, interval_d;

    logic [DATA_W-1:0] delta;
    logic              change, step_up, step_dn, step_ok, rate_ok;
    logic              in_slow, in_fast, stall_hit;
    logic [CNT_W-1:0]  meas;

    // In IDLE last_q is not yet a real sample, so no change is recognised.
    always_comb begin
        delta   = cnt_in - last_q;
        change  = (cnt_in != last_q) && (state_q != IDLE);
        step_up = (delta == DATA_W'(1));
        step_dn = (&delta);
        step_ok = step_up || step_dn;
        rate_ok = in_slow || in_fast;
    end

    step_interval_timer #(
        .CNT_W       (CNT_W),
        .SLOW_TICKS  (SLOW_TICKS),
        .FAST_TICKS  (FAST_TICKS),
        .TOL         (TOL),
        .STALL_TICKS (STALL_TICKS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (change || (state_q == IDLE)),
        .meas      (meas),
        .in_slow   (in_slow),
        .in_fast   (in_fast),
        .stall_hit (stall_hit)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = cnt_in;
        evt_d      = 1'b0;
        dir_d      = dir_q;
        hz_d       = hz_q;
        valid_d    = valid_q;
        step_err_d = step_err_q;
        rate_err_d = rate_err_q;
        stalled_d  = stalled_q;
        interval_d = interval_q;

        if (state_q == IDLE) begin
            state_d = WAIT;
        end else if (change) begin
            evt_d      = 1'b1;
            stalled_d  = 1'b0;
            interval_d = meas;
            if (step_up) begin
                dir_d = DIR_UP;
            end else if (step_dn) begin
                dir_d = DIR_DOWN;
            end else begin
                step_err_d = 1'b1;
                valid_d    = 1'b0;
            end

            // The first change after reset or a stall has no trustworthy interval.
            if (state_q == WAIT) begin
                state_d = ARMED;
            end else begin
                if (in_slow) begin
                    hz_d = RATE_SLOW;
                end else if (in_fast) begin
                    hz_d = RATE_FAST;
                end else begin
                    rate_err_d = 1'b1;
                    valid_d    = 1'b0;
                end
                if (step_ok && rate_ok) begin
                    valid_d = 1'b1;
                    state_d = LOCKED;
                end else begin
                    state_d = ARMED;
                end
            end
        end else if (stall_hit) begin
            stalled_d = 1'b1;
            valid_d   = 1'b0;
            state_d   = WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= '0;
            evt_q      <= 1'b0;
            dir_q      <= 1'b0;
            hz_q       <= 1'b0;
            valid_q    <= 1'b0;
            step_err_q <= 1'b0;
            rate_err_q <= 1'b0;
            stalled_q  <= 1'b0;
            interval_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            evt_q      <= evt_d;
            dir_q      <= dir_d;
            hz_q       <= hz_d;
            valid_q    <= valid_d;
            step_err_q <= step_err_d;
            rate_err_q <= rate_err_d;
            stalled_q  <= stalled_d;
            interval_q <= interval_d;
        end
    end

    assign evt       = evt_q;
    assign dir       = dir_q;
    assign hz_det    = hz_q;
    assign valid     = valid_q;
    assign step_err  = step_err_q;
    assign rate_err  = rate_err_q;
    assign stalled   = stalled_q;
    assign interval  = interval_q;
    assign state_dbg = state_q;

endmodule
